// File: rtl/sd_block_rx_if.sv
// sd_block_rx_if: start/byte-stream handshake, completion status and sector read port of sd_block_rx.
interface sd_block_rx_if #(parameter int ADDR_W = 9);
  logic              blk_start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              busy;
  logic              done;
  logic [1:0]        status;
  logic              buf_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  modport master (
    output blk_start, in_valid, in_data, rd_addr,
    input  busy, done, status, buf_valid, rd_data
  );
  modport slave (
    input  blk_start, in_valid, in_data, rd_addr,
    output busy, done, status, buf_valid, rd_data
  );
endinterface

// File: rtl/sd_block_rx.sv
// sd_block_rx: SPI-mode SD block receiver (token hunt, sector buffer, CRC16 trailer).
// Define SD_BLK_CRC_EN to compute and check the payload CRC16-CCITT.
module sd_block_rx #(
  parameter int BLOCK_BYTES   = 512,
  parameter int ADDR_W        = 9,
  parameter int TOKEN_TIMEOUT = 4096
) (
  input logic          clk,
  input logic          rst,
  sd_block_rx_if.slave bus
);
  localparam int TW = $clog2(TOKEN_TIMEOUT + 1);
  localparam logic [ADDR_W:0] LAST_BYTE = (ADDR_W+1)'(BLOCK_BYTES - 1);
  localparam logic [TW-1:0]   TOK_MAX   = TW'(TOKEN_TIMEOUT);
  typedef enum logic [2:0] {IDLE, WAIT_TOK, DATA, CRC_HI, CRC_LO, DONE} state_t;
  state_t          state_q, state_d;
  logic [TW-1:0]   tok_cnt_q, tok_cnt_d, tok_inc;
  logic [ADDR_W:0] byte_cnt_q, byte_cnt_d;
  logic [1:0]      status_q, status_d;
  logic            buf_valid_q, buf_valid_d;
  logic [7:0]      rd_data_q;
  logic [7:0]      mem [2**ADDR_W];
  logic            start, wr_en, busy, done, crc_ok;
`ifdef SD_BLK_CRC_EN
  logic [15:0] crc_q;
  logic [7:0]  crc_hi_q;
  function automatic logic [15:0] crc_fold(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? {r[14:0], 1'b0} ^ 16'h1021 : {r[14:0], 1'b0};
    return r;
  endfunction
  always_ff @(posedge clk) begin
    if (rst || start) crc_q <= '0;
    else if (wr_en) crc_q <= crc_fold(crc_q, bus.in_data);
    if (state_q == CRC_HI && bus.in_valid) crc_hi_q <= bus.in_data;
  end
  assign crc_ok = {crc_hi_q, bus.in_data} == crc_q;
`else
  assign crc_ok = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tok_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      status_q    <= '0;
      buf_valid_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      tok_cnt_q   <= tok_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      status_q    <= status_d;
      buf_valid_q <= buf_valid_d;
      rd_data_q   <= mem[bus.rd_addr];
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[byte_cnt_q[ADDR_W-1:0]] <= bus.in_data;
  end
  assign tok_inc = (tok_cnt_q == TOK_MAX) ? tok_cnt_q : tok_cnt_q + 1'b1;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.blk_start) state_d = WAIT_TOK;
      WAIT_TOK: if (bus.in_valid) state_d = (bus.in_data == 8'hFE) ? DATA :
                  (bus.in_data[7:4] == 4'h0 || tok_inc == TOK_MAX) ? DONE : WAIT_TOK;
      DATA:     if (bus.in_valid && byte_cnt_q == LAST_BYTE) state_d = CRC_HI;
      CRC_HI:   if (bus.in_valid) state_d = CRC_LO;
      CRC_LO:   if (bus.in_valid) state_d = DONE;
      default:  state_d = IDLE;
    endcase
  end
  always_comb begin
    start = state_q == IDLE && bus.blk_start;
    wr_en = state_q == DATA && bus.in_valid;
    busy  = state_q != IDLE && state_q != DONE;
    done  = state_q == DONE;
  end
  // Status and buf_valid load on the edge entering DONE so they are valid alongside done.
  always_comb begin
    tok_cnt_d   = start ? '0 : (state_q == WAIT_TOK && bus.in_valid && bus.in_data != 8'hFE) ? tok_inc : tok_cnt_q;
    byte_cnt_d  = start ? '0 : wr_en ? byte_cnt_q + 1'b1 : byte_cnt_q;
    buf_valid_d = start ? 1'b0 : (state_q == CRC_LO && bus.in_valid) ? crc_ok : buf_valid_q;
    status_d    = status_q;
    if (state_q == WAIT_TOK && bus.in_valid && bus.in_data != 8'hFE)
      status_d = (bus.in_data[7:4] == 4'h0) ? 2'b10 : (tok_inc == TOK_MAX) ? 2'b11 : status_q;
    if (state_q == CRC_LO && bus.in_valid) status_d = crc_ok ? 2'b00 : 2'b01;
  end
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.status    = status_q;
  assign bus.buf_valid = buf_valid_q;
  assign bus.rd_data   = rd_data_q;
endmodule

// File: tb/tb_sd_block_rx.sv
// tb_sd_block_rx: directed checks of sd_block_rx (token hunt, payload buffer, CRC trailer, timeout, reset).
module tb_sd_block_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [15:0] pat_crc;
  sd_block_rx_if #(.ADDR_W(9)) bus ();
  sd_block_rx #(.BLOCK_BYTES(512), .ADDR_W(9), .TOKEN_TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
`ifdef SD_BLK_CRC_EN
  localparam logic [1:0] E_BAD_ST = 2'b01;
  localparam logic       E_BAD_BV = 1'b0;
`else
  localparam logic [1:0] E_BAD_ST = 2'b00;
  localparam logic       E_BAD_BV = 1'b1;
`endif
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic fb;
    for (int k = 7; k >= 0; k--) begin
      fb = c[15] ^ b[k];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    bus.blk_start = 1'b1;
    tick();
    bus.blk_start = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input bit gap);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    if (gap) tick();
  endtask
  task automatic frame(input bit pat, input bit gap, input logic [7:0] hi, input logic [7:0] lo);
    pulse_start();
    chk("busy_after_start", {15'd0, bus.busy}, 16'd1);
    for (int i = 0; i < 3; i++) send(8'hFF, 1'b0);
    send(8'hFE, 1'b0);
    for (int i = 0; i < 512; i++) begin
      send(pat ? 8'(i) : 8'hFF, gap);
      if (gap && i == 100) pulse_start();
    end
    send(hi, 1'b0);
    chk("busy_before_lo", {15'd0, bus.busy}, 16'd1);
    send(lo, 1'b0);
  endtask
  initial begin
    bus.blk_start = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.rd_addr   = '0;
    pat_crc = '0;
    for (int i = 0; i < 512; i++) pat_crc = crc_byte(pat_crc, 8'(i));
    tick();
    tick();
    chk("rst_busy", {15'd0, bus.busy}, 16'd0);
    chk("rst_done", {15'd0, bus.done}, 16'd0);
    chk("rst_status", {14'd0, bus.status}, 16'd0);
    chk("rst_buf_valid", {15'd0, bus.buf_valid}, 16'd0);
    chk("rst_rd_data", {8'd0, bus.rd_data}, 16'd0);
    rst = 1'b0;
    tick();
    // Good all-0xFF frame, with a stray byte coinciding with the start pulse.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h09;
    frame(1'b0, 1'b0, 8'h7F, 8'hA1);
    chk("f1_done", {15'd0, bus.done}, 16'd1);
    chk("f1_busy", {15'd0, bus.busy}, 16'd0);
    chk("f1_status", {14'd0, bus.status}, 16'd0);
    chk("f1_buf_valid", {15'd0, bus.buf_valid}, 16'd1);
    bus.rd_addr = 9'd0;
    tick();
    chk("f1_done_pulse", {15'd0, bus.done}, 16'd0);
    chk("f1_rd0", {8'd0, bus.rd_data}, 16'h00FF);
    bus.rd_addr = 9'd511;
    tick();
    chk("f1_rd511", {8'd0, bus.rd_data}, 16'h00FF);
    chk("f1_status_hold", {14'd0, bus.status}, 16'd0);
    // Same frame with a corrupted CRC low byte.
    frame(1'b0, 1'b0, 8'h7F, 8'hA0);
    chk("f2_done", {15'd0, bus.done}, 16'd1);
    chk("f2_status", {14'd0, bus.status}, {14'd0, E_BAD_ST});
    chk("f2_buf_valid", {15'd0, bus.buf_valid}, {15'd0, E_BAD_BV});
    tick();
    // Counting pattern, in_valid every other cycle, ignored blk_start after byte 100.
    frame(1'b1, 1'b1, pat_crc[15:8], pat_crc[7:0]);
    chk("f3_done", {15'd0, bus.done}, 16'd1);
    chk("f3_status", {14'd0, bus.status}, 16'd0);
    chk("f3_buf_valid", {15'd0, bus.buf_valid}, 16'd1);
    for (int a = 0; a < 512; a += 51) begin
      bus.rd_addr = 9'(a);
      tick();
      chk($sformatf("f3_rd%0d", a), {8'd0, bus.rd_data}, {8'd0, 8'(a)});
    end
    bus.rd_addr = 9'd511;
    tick();
    chk("f3_rd511", {8'd0, bus.rd_data}, 16'h00FF);
    // Data error token.
    pulse_start();
    chk("f4_buf_valid_clr", {15'd0, bus.buf_valid}, 16'd0);
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    chk("f4_busy_wait", {15'd0, bus.busy}, 16'd1);
    chk("f4_no_done", {15'd0, bus.done}, 16'd0);
    send(8'h09, 1'b0);
    chk("f4_done", {15'd0, bus.done}, 16'd1);
    chk("f4_busy", {15'd0, bus.busy}, 16'd0);
    chk("f4_status", {14'd0, bus.status}, 16'd2);
    tick();
    // Token timeout after 16 non-token bytes.
    pulse_start();
    for (int i = 0; i < 15; i++) send(8'hFF, 1'b0);
    chk("f5_no_done_15", {15'd0, bus.done}, 16'd0);
    chk("f5_busy_15", {15'd0, bus.busy}, 16'd1);
    send(8'hFF, 1'b0);
    chk("f5_done", {15'd0, bus.done}, 16'd1);
    chk("f5_status", {14'd0, bus.status}, 16'd3);
    chk("f5_buf_valid", {15'd0, bus.buf_valid}, 16'd0);
    tick();
    // Reset in the middle of the payload, then a clean frame.
    pulse_start();
    send(8'hFE, 1'b0);
    for (int i = 0; i < 100; i++) send(8'(i), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("f6_busy", {15'd0, bus.busy}, 16'd0);
    chk("f6_done", {15'd0, bus.done}, 16'd0);
    chk("f6_status", {14'd0, bus.status}, 16'd0);
    chk("f6_buf_valid", {15'd0, bus.buf_valid}, 16'd0);
    chk("f6_rd_data", {8'd0, bus.rd_data}, 16'd0);
    tick();
    chk("f6_idle", {15'd0, bus.busy}, 16'd0);
    frame(1'b0, 1'b0, 8'h7F, 8'hA1);
    chk("f7_done", {15'd0, bus.done}, 16'd1);
    chk("f7_status", {14'd0, bus.status}, 16'd0);
    chk("f7_buf_valid", {15'd0, bus.buf_valid}, 16'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
